bos_spi_responder: RTL and testbench

//  SPI responder (slave) emulating the SBIS BOS control port. Answers the if_spi initiator at address 0x08
//  (CPOL=1, CPHA=0, 3-byte frames) so the FPGA can be loop-tested without the BOS part fitted.
//  All pins are oversampled in the sys_clk domain. Holds a local 16-bit register file, readable and writable over SPI.

---
 rtl/bos_spi_responder.sv | 217 +++++++++++++++++++++
 tb/tb_bos_spi_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bos_spi_responder.sv
// SPI responder emulating the SBIS BOS control port (CPOL=1, CPHA=0, 24-bit frames).
// Define SPI_RESP_ID_REG_EN to make address 0 a read-only ID register.
module bos_spi_responder #(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] ID_VALUE = 16'hB05A
) (
    input  logic        sys_clk,
    input  logic        n_rst,
    input  logic        sl,
    input  logic        sck,
    input  logic        sdatai,
    output logic        sdatao,
    output logic        sdatao_oe,
    output logic        wr_strobe,
    output logic [6:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    localparam int         AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NREG_W = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    logic        sl_meta_q, sl_sync_q, sl_prev_q;
    logic        sl_meta_d, sl_sync_d, sl_prev_d;
    logic        sck_meta_q, sck_sync_q, sck_prev_q;
    logic        sck_meta_d, sck_sync_d, sck_prev_d;
    logic        sdi_meta_q, sdi_sync_q;
    logic        sdi_meta_d, sdi_sync_d;
    logic [1:0]  fill_q, fill_d;
    logic        armed_q, armed_d;
    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic        overrun_q, overrun_d;
    logic        sdatao_q, sdatao_d;
    logic        oe_q, oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] regs_d [NUM_REGS];

    logic        sl_fall, sl_rise, sck_fall, sck_rise;
    logic [7:0]  hdr;
    logic [15:0] rd_val;
    logic        id_ro;

    function automatic logic addr_ok(input logic [6:0] a);
        return {1'b0, a} < NREG_W;
    endfunction

    assign sl_fall  = sl_prev_q & ~sl_sync_q;
    assign sl_rise  = ~sl_prev_q & sl_sync_q;
    assign sck_fall = sck_prev_q & ~sck_sync_q & ~sl_sync_q;
    assign sck_rise = ~sck_prev_q & sck_sync_q & ~sl_sync_q;
    assign hdr      = {sh_q[6:0], sdi_sync_q};

`ifdef SPI_RESP_ID_REG_EN
    assign id_ro = (addr_q == 7'd0);

    always_comb begin
        rd_val = '0;
        if (addr_ok(hdr[6:0])) rd_val = regs_q[hdr[AW-1:0]];
        if (hdr[6:0] == 7'd0) rd_val = ID_VALUE;
    end
`else
    logic unused_id;
    assign unused_id = ^ID_VALUE;
    assign id_ro     = 1'b0;

    always_comb begin
        rd_val = '0;
        if (addr_ok(hdr[6:0])) rd_val = regs_q[hdr[AW-1:0]];
    end
`endif

    always_comb begin
        sl_meta_d   = sl;
        sl_sync_d   = sl_meta_q;
        sl_prev_d   = sl_sync_q;
        sck_meta_d  = sck;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        sdi_meta_d  = sdatai;
        sdi_sync_d  = sdi_meta_q;
        // Ignore the synchroniser reset value until it reflects the real pin.
        fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d     = armed_q | ((fill_q == 2'd2) & sl_sync_q);
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        rd_sh_d     = rd_sh_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        overrun_d   = overrun_q;
        sdatao_d    = sdatao_q;
        oe_d        = oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        regs_d      = regs_q;

        unique case (state_q)
            IDLE: begin
                if (sl_fall && armed_q) begin
                    state_d   = HDR;
                    bit_cnt_d = '0;
                    overrun_d = 1'b0;
                    rw_d      = 1'b0;
                end
            end
            default: begin
                if (sl_rise) begin
                    state_d  = IDLE;
                    sdatao_d = 1'b0;
                    oe_d     = 1'b0;
                    if (bit_cnt_q == 5'd24 && !overrun_q) begin
                        if (!rw_q && addr_ok(addr_q) && !id_ro) begin
                            regs_d[addr_q[AW-1:0]] = sh_q;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = sh_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    sh_d = {sh_q[14:0], sdi_sync_q};
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                    if (state_q == HDR && bit_cnt_q == 5'd7) begin
                        rw_d    = hdr[7];
                        addr_d  = hdr[6:0];
                        state_d = DATA;
                        if (hdr[7]) rd_sh_d = rd_val;
                    end else if (state_q == DATA && bit_cnt_q == 5'd23) begin
                        state_d = DONE;
                    end else if (state_q == DONE) begin
                        overrun_d = 1'b1;
                    end
                end else if (sck_rise && state_q == DATA && rw_q) begin
                    sdatao_d = rd_sh_q[15];
                    rd_sh_d  = {rd_sh_q[14:0], 1'b0};
                    oe_d     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            sl_meta_q   <= 1'b1;
            sl_sync_q   <= 1'b1;
            sl_prev_q   <= 1'b1;
            sck_meta_q  <= 1'b1;
            sck_sync_q  <= 1'b1;
            sck_prev_q  <= 1'b1;
            sdi_meta_q  <= 1'b1;
            sdi_sync_q  <= 1'b1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            rd_sh_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            overrun_q   <= 1'b0;
            sdatao_q    <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            regs_q      <= '{default: '0};
        end else begin
            sl_meta_q   <= sl_meta_d;
            sl_sync_q   <= sl_sync_d;
            sl_prev_q   <= sl_prev_d;
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            sdi_meta_q  <= sdi_meta_d;
            sdi_sync_q  <= sdi_sync_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            rd_sh_q     <= rd_sh_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            overrun_q   <= overrun_d;
            sdatao_q    <= sdatao_d;
            oe_q        <= oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    assign sdatao    = sdatao_q;
    assign sdatao_oe = oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bos_spi_responder.sv
// Scoreboard bench for bos_spi_responder: bit-banged SPI initiator plus write/read queues.
// Build with SPI_RESP_ID_REG_EN defined to exercise the ID register variant.
module tb_bos_spi_responder;

    localparam int H = 8;

    logic        sys_clk = 1'b0;
    logic        n_rst   = 1'b0;
    logic        sl      = 1'b1;
    logic        sck     = 1'b1;
    logic        sdatai  = 1'b0;
    logic        sdatao;
    logic        sdatao_oe;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          err_seen = 0;
    int          exp_err  = 0;
    int          oe_hdr;
    int          oe_dat;
    logic [15:0] miso_cap;
    logic [22:0] wq [$];
    logic [15:0] rq [$];
    logic [22:0] wexp;

    always #5 sys_clk = ~sys_clk;

    bos_spi_responder dut (
        .sys_clk   (sys_clk),
        .n_rst     (n_rst),
        .sl        (sl),
        .sck       (sck),
        .sdatai    (sdatai),
        .sdatao    (sdatao),
        .sdatao_oe (sdatao_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    always @(negedge sys_clk) begin
        if (n_rst) begin
            if (frame_err) err_seen++;
            if (wr_strobe) begin
                if (wq.size() == 0) begin
                    check("wr_spurious", 32'(wr_strobe), 32'd0);
                end else begin
                    wexp = wq.pop_front();
                    check("wr_commit", {9'd0, wr_addr, wr_data}, {9'd0, wexp});
                end
            end
        end
    end

    task automatic xfer(input logic [23:0] fr, input int nbits, input bit close);
        oe_hdr   = 0;
        oe_dat   = 0;
        miso_cap = 'x;
        sl = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            sdatai = (i < 24) ? fr[23-i] : 1'b0;
            wait_clk(H);
            if (i < 8) begin
                oe_hdr += int'(sdatao_oe);
            end else if (i < 24) begin
                oe_dat += int'(sdatao_oe);
                miso_cap[23-i] = sdatao;
            end
            sck = 1'b0;
            wait_clk(H);
            sck = 1'b1;
        end
        wait_clk(H);
        if (close) begin
            sl = 1'b1;
            wait_clk(12);
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] d,
                            input bit commits);
        if (commits) wq.push_back({a, d});
        xfer({1'b0, a, d}, 24, 1'b1);
        check("wr_drain", wq.size(), 0);
        check("wr_oe", oe_hdr + oe_dat, 0);
        check("wr_err", err_seen, exp_err);
    endtask

    task automatic do_read(input logic [6:0] a, input logic [15:0] exp);
        rq.push_back(exp);
        xfer({1'b1, a, 16'h0000}, 24, 1'b1);
        check("rd_data", {16'd0, miso_cap}, {16'd0, rq.pop_front()});
        check("rd_oe_hdr", oe_hdr, 0);
        check("rd_oe_data", oe_dat, 16);
        check("rd_oe_end", {31'd0, sdatao_oe}, 32'd0);
        check("rd_do_end", {31'd0, sdatao}, 32'd0);
        check("rd_err", err_seen, exp_err);
    endtask

    initial begin
        wait_clk(5);
        n_rst = 1'b1;
        wait_clk(5);
        check("rst_sdatao", {31'd0, sdatao}, 32'd0);
        check("rst_oe", {31'd0, sdatao_oe}, 32'd0);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_addr", {25'd0, wr_addr}, 32'd0);
        check("rst_data", {16'd0, wr_data}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);

        do_write(7'h05, 16'h1234, 1'b1);
        do_read(7'h05, 16'h1234);
        do_write(7'h0A, 16'hC3A5, 1'b1);
        do_read(7'h0A, 16'hC3A5);
        do_read(7'h0F, 16'h0000);

        do_read(7'h20, 16'h0000);
        do_write(7'h20, 16'h5555, 1'b0);

        xfer({1'b0, 7'h03, 16'hABCD}, 16, 1'b1);
        exp_err++;
        check("short_err", err_seen, exp_err);
        do_read(7'h03, 16'h0000);

        xfer({1'b0, 7'h06, 16'hBEEF}, 25, 1'b1);
        exp_err++;
        check("long_err", err_seen, exp_err);
        do_read(7'h06, 16'h0000);

        for (int i = 0; i < 24; i++) begin
            sck = 1'b0;
            wait_clk(H);
            sck = 1'b1;
            wait_clk(H);
        end
        check("sck_idle_err", err_seen, exp_err);

        xfer({1'b0, 7'h09, 16'h1357}, 12, 1'b0);
        n_rst = 1'b0;
        wait_clk(4);
        n_rst = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 12; i++) begin
            sck = 1'b0;
            wait_clk(H);
            sck = 1'b1;
            wait_clk(H);
        end
        sl = 1'b1;
        wait_clk(12);
        check("abort_err", err_seen, exp_err);
        check("abort_nowr", wq.size(), 0);
        do_read(7'h05, 16'h0000);
        do_write(7'h07, 16'h00FF, 1'b1);
        do_read(7'h07, 16'h00FF);
        do_read(7'h09, 16'h0000);

`ifdef SPI_RESP_ID_REG_EN
        do_read(7'h00, 16'hB05A);
        do_write(7'h00, 16'h1111, 1'b0);
        do_read(7'h00, 16'hB05A);
`else
        do_read(7'h00, 16'h0000);
        do_write(7'h00, 16'h1111, 1'b1);
        do_read(7'h00, 16'h1111);
`endif

        wait_clk(10);
        check("end_wq", wq.size(), 0);
        check("end_err", err_seen, exp_err);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
